chen_seq: RTL
=============

Name: chen_seq

Overview:
- Run controller for the Chen oscillator iteration datapath. It replaces the simple start/enable unit.
- It drives the datapath's state-register enable (en_o) and initial-condition mux select (sel_o).
- Each Euler step is paced by a programmable clock divider, and each step runs for a bounded or unbounded iteration count.
- Each new (x,y,z) sample is presented to a downstream consumer (DAC/UART packer) through a valid/ready handshake with backpressure.

Parameters:
- CntWidth, 32, width of the iteration count input and the iteration counter.
- DivWidth, 16, width of the step-period input.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  begins a run when in IDLE; ignored otherwise.
- stop_i  input  1  requests early termination of a run.
- n_iter_i  input  CntWidth  number of steps per run; 0 = free-run. Latched at start.
- div_i  input  DivWidth  minimum clock cycles between en_o pulses. Latched at start.
- ready_i  input  1  consumer accepts the current sample.
- en_o  output  1  datapath register enable, one-cycle pulse per step.
- sel_o  output  1  0 = datapath uses ROM initial conditions, 1 = feedback.
- valid_o  output  1  datapath outputs hold a new, unconsumed sample.
- busy_o  output  1  run in progress.
- done_o  output  1  one-cycle pulse at run end.
- iter_cnt_o  output  CntWidth  steps completed in the current/last run.

Behaviour:
- Reset (async, rst_i=1):
  - State goes to IDLE.
  - All outputs are 0; iter_cnt_o = 0.
  - The internal stop flag, pace counter and first-step flag are cleared.
  - Reset mid-run aborts immediately, with no done_o.
- State IDLE:
  - en_o=0, sel_o=0, valid_o=0, busy_o=0.
  - On start_i=1: latch n_iter_q and div_q, clear iter_cnt_o, set first=1, go to STEP.
- State STEP (one cycle):
  - en_o=1; sel_o = ~first; busy_o=1.
  - Clear first; iter_cnt_o increments at the clock edge; reset the pace counter to 1.
  - Go to PRESENT.
- State PRESENT:
  - valid_o=1, sel_o=1; the pace counter increments, saturating at its maximum.
  - On ready_i=1 (handshake, valid drops next cycle), the next state is decided in this priority:
    - DONE if stop flag set, or (n_iter_q≠0 and iter_cnt_o==n_iter_q).
    - STEP if pace counter ≥ div_q-1.
    - Otherwise PACE.
  - ready_i=0: stay in PRESENT, with valid_o held and outputs stable.
- State PACE:
  - valid_o=0, sel_o=1; the pace counter increments.
  - Go to STEP when pace counter ≥ div_q-1.
- State DONE (one cycle):
  - done_o=1, sel_o=0, busy_o=1; go to IDLE.
  - iter_cnt_o holds its final value until the next start.
- Step period:
  - With ready_i held high, consecutive en_o pulses are exactly max(2, div_q) cycles apart.
  - div_q ∈ {0,1,2} all give period 2.
- Stall after pacing: if the consumer stalls longer than the period, STEP follows immediately in the cycle after the handshake.
- stop_i:
  - Sampled in every non-IDLE state and sets a sticky stop flag.
  - No further en_o is issued.
  - A sample already presented still completes its handshake before DONE.
  - stop_i in STEP lets that step finish.
  - stop_i in IDLE is ignored.
- Simultaneous events:
  - start_i while busy_o=1 is ignored.
  - stop_i together with the final-count handshake gives a single DONE.
  - start_i in the DONE cycle is ignored; it is accepted from IDLE the next cycle.
- Free-run (n_iter_q=0): iter_cnt_o wraps from 2^CntWidth-1 to 0 and the run continues; only stop_i ends it.
- Latency: start_i high at edge k gives en_o high in cycle k+1 with sel_o=0. The first sample is valid from cycle k+2.
- sel_o is 0 only in IDLE, DONE and the first STEP. The datapath's registered outputs are therefore valid whenever valid_o=1.

Test Plan:
- Reset mid-run: assert rst_i asynchronously during PRESENT → all outputs 0 immediately, state IDLE, next start_i behaves as a fresh run (first en_o with sel_o=0).
- Bounded run: n_iter_i=4, div_i=5, ready_i=1, start at cycle 0 → en_o at cycles 1,6,11,16; sel_o=0 only at cycle 1; valid_o at 2,7,12,17; done_o at 18; iter_cnt_o=4 afterwards.
- Minimum period: div_i=0, n_iter_i=3, ready_i=1 → en_o every 2 cycles; 3 pulses; done_o once; busy_o low after DONE.
- Backpressure: div_i=2, ready_i low for 10 cycles after the first valid → valid_o held 10 cycles, no en_o; ready_i high → handshake, en_o the very next cycle.
- Early stop, free-run: n_iter_i=0, div_i=3; pulse stop_i during PACE after step 7 → no 8th en_o, done_o next cycle, iter_cnt_o=7. Pulse stop_i during PRESENT with ready_i=0 → waits for handshake, then done_o.
- Ignored start: pulse start_i while busy_o=1 and during DONE → no change to n_iter_q/iter_cnt_o; start_i in the following IDLE cycle starts a new run.

Source files
------------

// File: rtl/chen_seq.sv
// chen_seq: run controller for the Chen oscillator datapath.
// Paces Euler steps with a programmable divider and hands each sample over a valid/ready link.
module chen_seq #(
    parameter int CntWidth = 32,
    parameter int DivWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [CntWidth-1:0] n_iter_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic                ready_i,
    output logic                en_o,
    output logic                sel_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CntWidth-1:0] iter_cnt_o
);
    typedef enum logic [2:0] {IDLE, STEP, PRESENT, PACE, DONE} state_t;
    state_t              r_state;
    logic                r_first;
    logic                r_stop;
    logic [DivWidth-1:0] r_div;
    logic [DivWidth-1:0] r_pace;
    logic [CntWidth-1:0] r_n;
    logic [CntWidth-1:0] r_cnt;
    logic                w_stop;
    logic                w_last;
    logic                w_paced;
    logic [DivWidth:0]   w_pace1;
    logic [DivWidth-1:0] w_pace_nxt;
    assign w_stop     = r_stop | stop_i;
    assign w_last     = (r_n != '0) && (r_cnt == r_n);
    // pace+1 >= div avoids the div-1 underflow for div of 0
    assign w_pace1    = {1'b0, r_pace} + {{DivWidth{1'b0}}, 1'b1};
    assign w_paced    = w_pace1 >= {1'b0, r_div};
    assign w_pace_nxt = (&r_pace) ? r_pace : w_pace1[DivWidth-1:0];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_first <= 1'b0;
            r_stop  <= 1'b0;
            r_div   <= '0;
            r_pace  <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_n     <= n_iter_i;
                    r_div   <= div_i;
                    r_cnt   <= '0;
                    r_first <= 1'b1;
                    r_stop  <= 1'b0;
                    r_state <= STEP;
                end
                STEP: begin
                    r_first <= 1'b0;
                    r_cnt   <= r_cnt + CntWidth'(1);
                    r_pace  <= DivWidth'(1);
                    r_stop  <= w_stop;
                    r_state <= PRESENT;
                end
                PRESENT: begin
                    r_pace <= w_pace_nxt;
                    r_stop <= w_stop;
                    if (ready_i)
                        r_state <= (w_stop || w_last) ? DONE : (w_paced ? STEP : PACE);
                end
                PACE: begin
                    r_pace  <= w_pace_nxt;
                    r_stop  <= w_stop;
                    r_state <= w_stop ? DONE : (w_paced ? STEP : PACE);
                end
                DONE: begin
                    r_stop  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign en_o       = r_state == STEP;
    assign sel_o      = (r_state == STEP && !r_first) || r_state == PRESENT || r_state == PACE;
    assign valid_o    = r_state == PRESENT;
    assign busy_o     = r_state != IDLE;
    assign done_o     = r_state == DONE;
    assign iter_cnt_o = r_cnt;
endmodule
